lfsr_seq_checker: RTL and testbench
===================================

LFSR_SEQ_CHECKER -- requirements
Module: lfsr_seq_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, number of consecutive correct predictions needed to declare lock.
REQ-002 SHALL have parameter LOSS_CNT, default 3, number of consecutive mispredictions while locked that drop lock.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_in  input  1  data_in carries a sample this cycle.
REQ-006 SHALL have port data_in  input  6  LFSR word q[5:0] from the upstream generator.
REQ-007 SHALL have port clear  input  1  synchronous clear of the error counter.
REQ-008 SHALL have port locked  output  1  high while the FSM is in LOCKED.
REQ-009 SHALL have port err_pulse  output  1  one-cycle pulse per misprediction while locked.
REQ-010 SHALL have port err_cnt  output  8  saturating count of mispredictions while locked.
REQ-011 SHALL have ports period (output, 7 bits) and period_valid (output, 1 bit), present only per REQ-024.

Function
REQ-012 SHALL use next(x) with n0=x5, n1=x0^x5, n2=x1^x5, n3=x2, n4=x3^x5, n5=x4.
REQ-013 SHALL implement FSM states HUNT, SYNC and LOCKED, with all outputs registered.
REQ-014 SHALL hold all state, pred and counters when valid_in=0.
REQ-015 In HUNT, a valid nonzero sample SHALL load pred=next(data_in), clear match_cnt and go to SYNC; a valid 6'b000000 sample SHALL be ignored.
REQ-016 In SYNC, a match SHALL increment match_cnt and set pred=next(data_in).
REQ-017 In SYNC, when match_cnt reaches LOCK_CNT, the FSM SHALL go to LOCKED.
REQ-018 In SYNC, a mismatch SHALL clear match_cnt, set pred=next(data_in) and keep the FSM in SYNC; err_cnt SHALL be unaffected.
REQ-019 In LOCKED, pred SHALL advance as pred=next(pred) on every valid sample, ignoring data_in (flywheel).
REQ-020 In LOCKED, a match SHALL clear miss_cnt.
REQ-021 In LOCKED, a mismatch SHALL assert err_pulse on the next cycle, increment err_cnt (saturating at 255) and increment miss_cnt; when miss_cnt reaches LOSS_CNT, the FSM SHALL go to HUNT.
REQ-022 clear SHALL set err_cnt=0 and SHALL win over a simultaneous error; clear SHALL NOT affect the FSM.

Reset
REQ-023 While rst=0, the block SHALL force state=HUNT, pred=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_cnt=0, period=0 and period_valid=0; assertion mid-operation SHALL abort immediately.

Configuration
REQ-024 With macro LFSR_CHK_PERIOD_EN defined, the block SHALL count valid samples in LOCKED, latch the count into period and reset it to 1 on each matched 6'b111111, set period_valid after the first complete latch, and clear both outputs on leaving LOCKED; without the macro, the ports and logic SHALL be absent.

Structure
REQ-025 Shared package lfsr_pkg SHALL hold the FSM state typedef, LFSR_W=6, LFSR_SEED=6'b111111 and the tap constants.
REQ-026 Combinational sub-module lfsr6_next (x in, next(x) out) SHALL compute next(); it is reused by the upstream generator bench.

Verification
REQ-027 Drive rst=0 -> locked=0, err_cnt=0, err_pulse=0 and period_valid=0 regardless of clk and inputs.
REQ-028 After rst=1, drive valid=1 with the correct stream 111111, 101001, 000101, ... -> locked=1 in the cycle after the 5th sample; err_cnt stays 0.
REQ-029 While locked, corrupt one sample (flip bit 0) -> err_pulse high for exactly one cycle, err_cnt=1, locked stays 1, and the following correct sample matches.
REQ-030 While locked, corrupt 3 consecutive samples -> err_cnt=3, locked falls after the 3rd mispredicted sample, FSM returns to HUNT, and relock requires LOCK_CNT matches.
REQ-031 Drive valid_in toggling 1/0 over a correct stream -> lock and period value identical to the continuous case; period_valid=1 after the second seed occurrence (macro on).
REQ-032 Hold data_in=000000 with valid=1 in HUNT -> stays HUNT; assert clear in the same cycle as a locked error -> err_cnt=0, err_pulse=1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 6-bit LFSR sequence checker: width, seed,
// feedback taps and the checker FSM state type.
package lfsr_pkg;

  localparam int LFSR_W = 6;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 6'b111111;

  // q[5] rotates into bit 0 and is also XORed into bits 1, 2 and 4
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 6'b010110;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr6_next.sv
// Combinational next-state function of the 6-bit Galois LFSR.
module lfsr6_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] x,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = {x[LFSR_W-2:0], x[LFSR_W-1]} ^ (LFSR_TAPS & {LFSR_W{x[LFSR_W-1]}});

endmodule

// File: rtl/lfsr_seq_checker.sv
// Locks onto an upstream 6-bit LFSR stream, then flywheels and counts errors.
// Optional seed-to-seed period measurement is enabled by LFSR_CHK_PERIOD_EN.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [7:0]        err_cnt
`ifdef LFSR_CHK_PERIOD_EN
  ,
  output logic [6:0]        period,
  output logic              period_valid
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  state_t            state, state_next;
  logic [LFSR_W-1:0] pred, pred_next, data_adv, pred_adv;
  logic [MW-1:0]     match_cnt, match_next;
  logic [LW-1:0]     miss_cnt, miss_next;
  logic              hit, err_hit;

  lfsr6_next u_data_next (.x(data_in), .nxt(data_adv));
  lfsr6_next u_pred_next (.x(pred),    .nxt(pred_adv));

  assign hit = (data_in == pred);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      state     <= state_next;
      pred      <= pred_next;
      match_cnt <= match_next;
      miss_cnt  <= miss_next;
    end
  end

  always_comb begin
    state_next = state;
    pred_next  = pred;
    match_next = match_cnt;
    miss_next  = miss_cnt;
    err_hit    = 1'b0;
    if (valid_in) begin
      unique case (state)
        HUNT: begin
          if (data_in != '0) begin
            pred_next  = data_adv;
            match_next = '0;
            state_next = SYNC;
          end
        end
        SYNC: begin
          pred_next = data_adv;
          if (hit) begin
            match_next = match_cnt + MW'(1);
            if (int'(match_cnt) + 1 >= LOCK_CNT) begin
              state_next = LOCKED;
              miss_next  = '0;
            end
          end else begin
            match_next = '0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction ignores incoming data once locked
          pred_next = pred_adv;
          if (hit) begin
            miss_next = '0;
          end else begin
            err_hit = 1'b1;
            if (int'(miss_cnt) + 1 >= LOSS_CNT) begin
              state_next = HUNT;
              miss_next  = '0;
            end else begin
              miss_next = miss_cnt + LW'(1);
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      locked    <= (state_next == LOCKED);
      err_pulse <= err_hit;
      if (clear) begin
        err_cnt <= '0;
      end else if (err_hit && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

`ifdef LFSR_CHK_PERIOD_EN
  logic [6:0] per_cnt;
  logic       seed_seen;

  // The first matched seed after lock only starts the count; later ones latch it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt      <= '0;
      seed_seen    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (state_next != LOCKED) begin
      per_cnt      <= '0;
      seed_seen    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (valid_in && (state == LOCKED)) begin
      if (hit && (data_in == LFSR_SEED)) begin
        if (seed_seen) begin
          period       <= per_cnt;
          period_valid <= 1'b1;
        end
        per_cnt   <= 7'd1;
        seed_seen <= 1'b1;
      end else if (per_cnt != '1) begin
        per_cnt <= per_cnt + 7'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: directed vector table, hand-written
// reset/toggle/saturation sequences and randomized traffic against a reference model.
module tb_lfsr_seq_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [5:0] data_in;
  logic       clear;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
`ifdef LFSR_CHK_PERIOD_EN
  logic [6:0] period;
  logic       period_valid;
`endif

  lfsr_seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
`ifdef LFSR_CHK_PERIOD_EN
    ,
    .period       (period),
    .period_valid (period_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int s[64];

  // Reference model state: mode 0=hunting, 1=syncing, 2=locked
  int m_mode, m_pred, m_match, m_miss, m_err;
  bit m_pulse;
`ifdef LFSR_CHK_PERIOD_EN
  int m_pcnt, m_period;
  bit m_seen, m_pv;
`endif

  typedef struct {
    bit v;
    bit z;
    int idx;
    bit flip;
    bit clr;
    bit e_lock;
    bit e_pulse;
    int e_err;
  } vec_t;
  vec_t tbl[25];

  // Multiplication by x modulo x^6+x^4+x^2+x+1
  function automatic int mnext(int x);
    int y;
    y = x * 2;
    if (y >= 64) y = y ^ 'h57;
    return y;
  endfunction

  task automatic check(string nm, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pred = 0; m_match = 0; m_miss = 0; m_err = 0; m_pulse = 0;
`ifdef LFSR_CHK_PERIOD_EN
    m_pcnt = 0; m_period = 0; m_seen = 0; m_pv = 0;
`endif
  endtask

  task automatic model_step(bit v, int d, bit c);
    bit hit;
    hit = (d == m_pred);
    m_pulse = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin
          m_pred = mnext(d); m_match = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (hit) begin
          m_match++;
          if (m_match >= LOCK_CNT) begin
            m_mode = 2; m_miss = 0;
          end
        end else begin
          m_match = 0;
        end
        m_pred = mnext(d);
      end else begin
`ifdef LFSR_CHK_PERIOD_EN
        if (hit && d == 63) begin
          if (m_seen) begin m_period = m_pcnt; m_pv = 1; end
          m_pcnt = 1; m_seen = 1;
        end else if (m_pcnt < 127) begin
          m_pcnt++;
        end
`endif
        if (hit) begin
          m_miss = 0;
        end else begin
          m_pulse = 1;
          if (m_err < 255) m_err++;
          m_miss++;
          if (m_miss >= LOSS_CNT) begin m_mode = 0; m_miss = 0; end
        end
        m_pred = mnext(m_pred);
      end
    end
`ifdef LFSR_CHK_PERIOD_EN
    if (m_mode != 2) begin m_pcnt = 0; m_seen = 0; m_period = 0; m_pv = 0; end
`endif
    if (c) m_err = 0;
  endtask

  task automatic drive(bit v, logic [5:0] d, bit c);
    @(negedge clk);
    valid_in = v; data_in = d; clear = c;
    @(posedge clk);
    model_step(v, int'(d), c);
    #1;
  endtask

  task automatic compare_model();
    check("locked", int'(locked), (m_mode == 2) ? 1 : 0);
    check("err_pulse", int'(err_pulse), int'(m_pulse));
    check("err_cnt", int'(err_cnt), m_err);
`ifdef LFSR_CHK_PERIOD_EN
    check("period", int'(period), m_period);
    check("period_valid", int'(period_valid), int'(m_pv));
`endif
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_err_pulse"}, int'(err_pulse), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
`ifdef LFSR_CHK_PERIOD_EN
    check({tag, "_period_valid"}, int'(period_valid), 0);
    check({tag, "_period"}, int'(period), 0);
`endif
  endtask

  // Asserts reset between clock edges, then holds it over edges with live inputs
  task automatic reset_phase(string tag);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs({tag, "_async"});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in = 1'b1; data_in = 6'($urandom); clear = 1'($urandom);
      @(posedge clk);
      #1;
      check_reset_outputs({tag, "_held"});
    end
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0; data_in = '0; clear = 1'b0;
    model_reset();
  endtask

  initial begin : main
    int g;
    int per_ref;
    int x;
    int burst;
    logic [5:0] d;

    rst = 1'b0; valid_in = 1'b0; data_in = '0; clear = 1'b0;
    model_reset();

    s[0] = 63;
    for (int i = 1; i < 64; i++) s[i] = mnext(s[i-1]);
    per_ref = 1;
    x = mnext(63);
    for (int i = 0; i < 64 && x != 63; i++) begin
      x = mnext(x);
      per_ref++;
    end
    check("stream_s1", s[1], 'h29);
    check("stream_s2", s[2], 'h05);

    //              v  z  idx f  c  L  P  E
    tbl[0]  = '{1, 0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1,  0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 2,  0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 3,  0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 4,  0, 0, 1, 0, 0};
    tbl[5]  = '{1, 0, 5,  0, 0, 1, 0, 0};
    tbl[6]  = '{1, 0, 6,  1, 0, 1, 1, 1};
    tbl[7]  = '{1, 0, 7,  0, 0, 1, 0, 1};
    tbl[8]  = '{1, 0, 8,  0, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 20, 0, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 9,  1, 1, 1, 1, 0};
    tbl[11] = '{1, 0, 10, 0, 0, 1, 0, 0};
    tbl[12] = '{1, 0, 11, 1, 0, 1, 1, 1};
    tbl[13] = '{1, 0, 12, 1, 0, 1, 1, 2};
    tbl[14] = '{1, 0, 13, 1, 0, 0, 1, 3};
    tbl[15] = '{1, 1, 0,  0, 0, 0, 0, 3};
    tbl[16] = '{1, 1, 0,  0, 0, 0, 0, 3};
    tbl[17] = '{1, 0, 14, 0, 0, 0, 0, 3};
    tbl[18] = '{1, 0, 15, 0, 0, 0, 0, 3};
    tbl[19] = '{1, 0, 16, 0, 0, 0, 0, 3};
    tbl[20] = '{1, 0, 30, 0, 0, 0, 0, 3};
    tbl[21] = '{1, 0, 31, 0, 0, 0, 0, 3};
    tbl[22] = '{1, 0, 32, 0, 0, 0, 0, 3};
    tbl[23] = '{1, 0, 33, 0, 0, 0, 0, 3};
    tbl[24] = '{1, 0, 34, 0, 0, 1, 0, 3};

    // Power-up reset with clock running
    @(posedge clk);
    reset_phase("por");

    foreach (tbl[i]) begin
      d = tbl[i].z ? 6'd0 : (6'(s[tbl[i].idx]) ^ {5'd0, tbl[i].flip});
      drive(tbl[i].v, d, tbl[i].clr);
      check($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].e_lock));
      check($sformatf("tbl%0d_err_pulse", i), int'(err_pulse), int'(tbl[i].e_pulse));
      check($sformatf("tbl%0d_err_cnt", i), int'(err_cnt), tbl[i].e_err);
    end

    // Reset while locked with a nonzero error count
    reset_phase("mid");

    // Valid toggling over a correct stream from the seed
    for (int k = 0; k < 45; k++) begin
      drive(1'b1, 6'(s[k]), 1'b0);
      compare_model();
      if (k == 3) check("toggle_prelock", int'(locked), 0);
      if (k == 4) check("toggle_lock", int'(locked), 1);
      drive(1'b0, 6'($urandom), 1'b0);
      compare_model();
    end
    check("toggle_err_cnt", int'(err_cnt), 0);
`ifdef LFSR_CHK_PERIOD_EN
    check("toggle_period", int'(period), per_ref);
    check("toggle_period_valid", int'(period_valid), 1);
`endif

    // Alternate single errors with matches until the error counter saturates
    g = 45 % per_ref;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 6'(s[g]) ^ 6'd1, 1'b0);
      compare_model();
      g = (g + 1) % per_ref;
      drive(1'b1, 6'(s[g]), 1'b0);
      compare_model();
      g = (g + 1) % per_ref;
    end
    check("err_sat", int'(err_cnt), 255);
    check("err_sat_locked", int'(locked), 1);
    drive(1'b0, 6'd0, 1'b1);
    compare_model();
    check("clear_err_cnt", int'(err_cnt), 0);
    check("clear_locked", int'(locked), 1);

    // Randomized traffic: gaps, single errors, error bursts, zeros, jumps, clears
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v;
      int r;
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (burst > 0) begin
        d = 6'(s[g]) ^ (6'd1 << $urandom_range(0, 5));
        burst--;
      end else if (r < 2) begin
        d = 6'(s[g]) ^ (6'd1 << $urandom_range(0, 5));
        burst = 2;
      end else if (r < 7) begin
        d = 6'(s[g]) ^ (6'd1 << $urandom_range(0, 5));
      end else if (r < 9) begin
        d = 6'd0;
      end else if (r < 10) begin
        g = $urandom_range(0, per_ref - 1);
        d = 6'(s[g]);
      end else begin
        d = 6'(s[g]);
      end
      if (v) g = (g + 1) % per_ref;
      drive(v, d, ($urandom_range(0, 39) == 0));
      compare_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
